fifo_rd_framer: RTL

- Sits directly downstream of the FIFO read port in the clk_b domain.
- Pops 16-bit words from the FIFO (drives ren_b, consumes dout_b/empty) and emits them as framed packets on a valid/ready stream.
- Frame format: one header word, FRAME_LEN payload words, one checksum word.
- If the FIFO runs dry mid-frame, a timeout pads the frame so partial data is never stranded.

---
 rtl/fifo_rd_framer_pkg.sv | 22 ++
 rtl/fifo_rd_prefetch.sv | 62 ++++++
 rtl/fifo_rd_framer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_framer_pkg.sv
// Shared types and defaults for the FIFO read-side framer.
package fifo_rd_framer_pkg;

    localparam int unsigned SYNC_W = 8;
    localparam int unsigned SEQ_W  = 8;

    localparam logic [SYNC_W-1:0] SYNC_DEFAULT     = 8'hA5;
    localparam logic [15:0]       PAD_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_PAD,
        ST_CSUM
    } frm_state_e;

    typedef struct packed {
        logic [SYNC_W-1:0] sync;
        logic [SEQ_W-1:0]  seq;
    } hdr_t;

endpackage

// File: rtl/fifo_rd_prefetch.sv
// Two-entry prefetch buffer in front of the FIFO read port; one-cycle read latency.
module fifo_rd_prefetch #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout_b,
    input  logic              pop,
    output logic              ren_b,
    output logic              buf_valid,
    output logic              inflight,
    output logic [DATA_W-1:0] buf_data
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        cnt_after_pop;
    logic              inflight_q;
    logic              en_q;

    // en_q keeps ren_b low while reset is asserted and for the first edge after release
    assign ren_b     = en_q && !empty && ((cnt_q + 2'(inflight_q)) < 2'd2);
    assign buf_valid = (cnt_q != 2'd0);
    assign buf_data  = ent0_q;
    assign inflight  = inflight_q;

    always_comb begin
        ent0_d        = ent0_q;
        ent1_d        = ent1_q;
        cnt_after_pop = cnt_q - 2'(pop);
        if (pop) begin
            ent0_d = ent1_q;
        end
        if (inflight_q) begin
            if (cnt_after_pop == 2'd0) begin
                ent0_d = dout_b;
            end else begin
                ent1_d = dout_b;
            end
        end
        cnt_d = cnt_after_pop + 2'(inflight_q);
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_d;
            inflight_q <= ren_b;
            en_q       <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_framer.sv
// Pops FIFO words and emits header / FRAME_LEN payload / checksum frames on a valid/ready stream.
module fifo_rd_framer
    import fifo_rd_framer_pkg::*;
#(
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        FRAME_LEN = 8,
    parameter int unsigned        TIMEOUT   = 16,
    parameter logic [SYNC_W-1:0]  SYNC      = SYNC_DEFAULT,
    parameter logic [DATA_W-1:0]  PAD_WORD  = DATA_W'(PAD_WORD_DEFAULT)
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout_b,
    output logic              ren_b,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eof,
    output logic [15:0]       frames_sent
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned STARVE_W = $clog2(TIMEOUT + 1);

    frm_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [15:0]         frames_q, frames_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_sof_q, m_sof_d;
    logic                m_eof_q, m_eof_d;

    logic                pop;
    logic                buf_valid;
    logic                inflight;
    logic [DATA_W-1:0]   buf_data;
    logic                out_free;
    logic                word_avail;
    logic                start_frame;
    hdr_t                hdr;

    fifo_rd_prefetch #(
        .DATA_W (DATA_W)
    ) u_prefetch (
        .clk_b     (clk_b),
        .rst_n     (rst_n),
        .empty     (empty),
        .dout_b    (dout_b),
        .pop       (pop),
        .ren_b     (ren_b),
        .buf_valid (buf_valid),
        .inflight  (inflight),
        .buf_data  (buf_data)
    );

    assign out_free   = !m_valid_q || m_ready;
    // An in-flight read lands at this edge, so the header can go out alongside it
    assign word_avail = buf_valid || inflight;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        frames_d    = frames_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_sof_d     = m_sof_q;
        m_eof_d     = m_eof_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        hdr         = '{sync: SYNC, seq: '0};

        if (out_free) begin
            m_valid_d = 1'b0;
            m_sof_d   = 1'b0;
            m_eof_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                start_frame = out_free && word_avail;
            end
            ST_PAYLOAD: begin
                if (out_free) begin
                    if (buf_valid) begin
                        pop       = 1'b1;
                        m_data_d  = buf_data;
                        m_valid_d = 1'b1;
                        csum_d    = csum_q + buf_data;
                        cnt_d     = cnt_q + 1'b1;
                        starve_d  = '0;
                        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            state_d = ST_CSUM;
                        end
                    end else if (!inflight) begin
                        if (starve_q == STARVE_W'(TIMEOUT - 1)) begin
                            state_d  = ST_PAD;
                            starve_d = '0;
                        end else begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (out_free) begin
                    m_data_d  = PAD_WORD;
                    m_valid_d = 1'b1;
                    csum_d    = csum_q + PAD_WORD;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (out_free) begin
                    // m_eof_q marks the checksum already presented; out_free means it was taken
                    if (m_eof_q) begin
                        seq_d       = seq_q + 1'b1;
                        frames_d    = frames_q + 1'b1;
                        state_d     = ST_IDLE;
                        start_frame = word_avail;
                    end else begin
                        m_data_d  = csum_q;
                        m_valid_d = 1'b1;
                        m_eof_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hdr.seq = seq_d;
        if (start_frame) begin
            m_data_d  = DATA_W'(hdr);
            m_valid_d = 1'b1;
            m_sof_d   = 1'b1;
            m_eof_d   = 1'b0;
            state_d   = ST_PAYLOAD;
            cnt_d     = '0;
            csum_d    = '0;
            starve_d  = '0;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            csum_q    <= '0;
            seq_q     <= '0;
            frames_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            csum_q    <= csum_d;
            seq_q     <= seq_d;
            frames_q  <= frames_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_sof_q   <= m_sof_d;
            m_eof_q   <= m_eof_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_sof       = m_sof_q;
    assign m_eof       = m_eof_q;
    assign frames_sent = frames_q;

endmodule
